path_stepper: RTL and testbench

Downstream consumer of the A* search result. Captures the direction path, path length and no-path flag when the search reports completion. Replays the path as a valid/ready stream of step commands toward the motion controller. Tracks the robot's grid position while it does so, and flags any path that leaves the 10x10 grid, uses an illegal code, or does not finish on the goal cell.

---
 rtl/path_stepper.sv | 212 +++++++++++++++++++++
 tb/tb_path_stepper.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/path_stepper.sv
// path_stepper: replays a captured A* direction path as a valid/ready stream
// of step commands and tracks the robot's grid position on the 10x10 grid.
//
// Build option: define PATH_STEPPER_RLE_EN to merge runs of identical codes
// (up to 9 entries) into one command. Without it every entry is its own
// command and run_len is always 1.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   path_ready, no_path search outcome levels (acted on only when armed)
//   path_length, path   entry count (clamped to 99) and direction codes
//   dir_valid/ready     step command handshake; dir_data, run_len payload
//   pos_row, pos_col    committed robot position
//   busy                high in BUILD and STREAM
//   done, error, fail   one-cycle result pulses
module path_stepper #(
  parameter int START_ROW = 9,
  parameter int START_COL = 0,
  parameter int END_ROW   = 0,
  parameter int END_COL   = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             path_ready,
  input  logic             no_path,
  input  logic [6:0]       path_length,
  input  logic [0:98][3:0] path,
  output logic             dir_valid,
  input  logic             dir_ready,
  output logic [3:0]       dir_data,
  output logic [3:0]       run_len,
  output logic [3:0]       pos_row,
  output logic [3:0]       pos_col,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             fail
);

`ifdef PATH_STEPPER_RLE_EN
  localparam bit RleEn = 1'b1;
`else
  localparam bit RleEn = 1'b0;
`endif

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUILD  = 2'd1;
  localparam logic [1:0] STREAM = 2'd2;
  localparam logic [1:0] FINISH = 2'd3;

  localparam logic [3:0] SRow = 4'(START_ROW);
  localparam logic [3:0] SCol = 4'(START_COL);
  localparam logic [3:0] ERow = 4'(END_ROW);
  localparam logic [3:0] ECol = 4'(END_COL);

  localparam logic [3:0] N = 4'b0001, S = 4'b0010, W = 4'b0100, E = 4'b1000;

  logic [1:0]       state_q, state_d;
  logic             armed_q, armed_d;
  logic [0:98][3:0] buf_q, buf_d;
  logic [6:0]       len_q, len_d, idx_q, idx_d;
  logic [3:0]       row_q, row_d, col_q, col_d;
  logic [3:0]       sh_row_q, sh_row_d, sh_col_q, sh_col_d;
  logic [3:0]       dir_q, dir_d, run_q, run_d;
  logic             inrun_q, inrun_d;
  logic             done_q, done_d, error_q, error_d, fail_q, fail_d;

  // Keeps buffer reads in range; values past the clamp are never consumed.
  function automatic logic [6:0] clip(input logic [6:0] i);
    return (i > 7'd98) ? 7'd98 : i;
  endfunction

  // Entry under consideration: the run start, or the next entry to merge.
  logic [6:0] rd_idx, nx_idx;
  logic [3:0] code, base_row, base_col, mv_row, mv_col, new_run;
  logic       legal, off_grid, more;

  always_comb begin
    rd_idx   = inrun_q ? idx_q + {3'd0, run_q} : idx_q;
    nx_idx   = rd_idx + 7'd1;
    code     = buf_q[clip(rd_idx)];
    base_row = inrun_q ? sh_row_q : row_q;
    base_col = inrun_q ? sh_col_q : col_q;
    new_run  = inrun_q ? run_q + 4'd1 : 4'd1;
    legal    = (code == N) || (code == S) || (code == W) || (code == E);
    off_grid = 1'b0;
    mv_row   = base_row;
    mv_col   = base_col;
    case (code)
      N: begin off_grid = (base_row == 4'd0); mv_row = base_row - 4'd1; end
      S: begin off_grid = (base_row == 4'd9); mv_row = base_row + 4'd1; end
      W: begin off_grid = (base_col == 4'd0); mv_col = base_col - 4'd1; end
      E: begin off_grid = (base_col == 4'd9); mv_col = base_col + 4'd1; end
      default: ;
    endcase
    // Decide in the same cycle whether the following entry extends the run,
    // so each merged entry costs exactly one BUILD cycle.
    more = RleEn && (new_run < 4'd9) && (nx_idx < len_q) &&
           (buf_q[clip(nx_idx)] == code);
  end

  always_comb begin
    state_d  = state_q;
    armed_d  = armed_q;
    buf_d    = buf_q;
    len_d    = len_q;
    idx_d    = idx_q;
    row_d    = row_q;
    col_d    = col_q;
    sh_row_d = sh_row_q;
    sh_col_d = sh_col_q;
    dir_d    = dir_q;
    run_d    = run_q;
    inrun_d  = inrun_q;
    done_d   = 1'b0;
    error_d  = 1'b0;
    fail_d   = 1'b0;
    if (!path_ready && !no_path) armed_d = 1'b1;
    case (state_q)
      IDLE: if (armed_q) begin
        if (no_path) begin
          fail_d  = 1'b1;
          armed_d = 1'b0;
        end else if (path_ready) begin
          buf_d   = path;
          len_d   = (path_length > 7'd99) ? 7'd99 : path_length;
          row_d   = SRow;
          col_d   = SCol;
          idx_d   = '0;
          inrun_d = 1'b0;
          armed_d = 1'b0;
          state_d = BUILD;
        end
      end
      BUILD: begin
        if (!inrun_q && idx_q == len_q) begin
          state_d = FINISH;
        end else if (!legal || off_grid) begin
          error_d = 1'b1;
          inrun_d = 1'b0;
          state_d = IDLE;
        end else begin
          sh_row_d = mv_row;
          sh_col_d = mv_col;
          dir_d    = code;
          run_d    = new_run;
          inrun_d  = more;
          if (!more) state_d = STREAM;
        end
      end
      STREAM: if (dir_ready) begin
        row_d   = sh_row_q;
        col_d   = sh_col_q;
        idx_d   = idx_q + {3'd0, run_q};
        state_d = BUILD;
      end
      FINISH: begin
        if (row_q == ERow && col_q == ECol) done_d = 1'b1;
        else error_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      armed_q  <= 1'b1;
      buf_q    <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      row_q    <= SRow;
      col_q    <= SCol;
      sh_row_q <= SRow;
      sh_col_q <= SCol;
      dir_q    <= '0;
      run_q    <= 4'd1;
      inrun_q  <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      armed_q  <= armed_d;
      buf_q    <= buf_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      row_q    <= row_d;
      col_q    <= col_d;
      sh_row_q <= sh_row_d;
      sh_col_q <= sh_col_d;
      dir_q    <= dir_d;
      run_q    <= run_d;
      inrun_q  <= inrun_d;
      done_q   <= done_d;
      error_q  <= error_d;
      fail_q   <= fail_d;
    end
  end

  assign dir_valid = (state_q == STREAM);
  assign busy      = (state_q == BUILD) || (state_q == STREAM);
  assign dir_data  = dir_q;
  assign run_len   = run_q;
  assign pos_row   = row_q;
  assign pos_col   = col_q;
  assign done      = done_q;
  assign error     = error_q;
  assign fail      = fail_q;

endmodule

// File: tb/tb_path_stepper.sv
// Randomized + directed bench for path_stepper (start (9,0), goal (0,9)).
// Expected commands and outcome come from a path-walking model below.
module tb_path_stepper;
  localparam int SR = 9, SC = 0, ER = 0, EC = 9;
`ifdef PATH_STEPPER_RLE_EN
  localparam bit RLE = 1'b1;
`else
  localparam bit RLE = 1'b0;
`endif
  localparam logic [3:0] DN = 4'b0001, DS = 4'b0010, DW = 4'b0100, DE = 4'b1000;

  logic clk = 1'b0;
  logic rst, path_ready, no_path, dir_valid, dir_ready, busy, done, error, fail;
  logic [6:0] path_length;
  logic [0:98][3:0] path;
  logic [3:0] dir_data, run_len, pos_row, pos_col;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  path_stepper #(.START_ROW(SR), .START_COL(SC), .END_ROW(ER), .END_COL(EC)) dut (
    .clk(clk), .rst(rst), .path_ready(path_ready), .no_path(no_path),
    .path_length(path_length), .path(path), .dir_valid(dir_valid),
    .dir_ready(dir_ready), .dir_data(dir_data), .run_len(run_len),
    .pos_row(pos_row), .pos_col(pos_col), .busy(busy), .done(done),
    .error(error), .fail(fail)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int d; int n; int r; int c; } cmd_t;
  cmd_t exp_q[$];
  bit   exp_ok;
  int   fin_r, fin_c;

  // Moves (r,c) by one step of code d; returns 0 for an illegal code or off-grid.
  function automatic bit step(input int d, inout int r, inout int c);
    case (d)
      1: r = r - 1;
      2: r = r + 1;
      4: c = c - 1;
      8: c = c + 1;
      default: return 1'b0;
    endcase
    return (r >= 0 && r <= 9 && c >= 0 && c <= 9);
  endfunction

  task automatic model(input int len_in);
    int len, r, c, i;
    len = (len_in > 99) ? 99 : len_in;
    r = SR; c = SC; i = 0;
    exp_q.delete();
    exp_ok = 1'b0;
    while (i < len) begin
      int d, n, rr, cc;
      bit good;
      cmd_t e;
      d = int'(path[i]); n = 0; rr = r; cc = c;
      do begin
        good = step(d, rr, cc);
        n++; i++;
      end while (good && RLE && n < 9 && i < len && int'(path[i]) == d);
      if (!good) begin fin_r = r; fin_c = c; return; end
      e.d = d; e.n = n; e.r = rr; e.c = cc;
      exp_q.push_back(e);
      r = rr; c = cc;
    end
    fin_r = r; fin_c = c;
    exp_ok = (r == ER && c == EC);
  endtask

  // ---------------- driver / checker for one path ----------------
  task automatic run_path(input string tag, input int len, input int rdy_pct, input int stall_cmd);
    int cur_r, cur_c, ncmd, stall;
    bit hs, ended, seen;
    cur_r = SR; cur_c = SC; ncmd = 0; stall = 0; hs = 0; ended = 0; seen = 0;
    model(len);
    path_length = 7'(len);
    path_ready = 1'b1;
    @(negedge clk);
    path_ready = 1'b0;
    dir_ready = 1'b0;
    for (int cyc = 0; cyc < 3000 && !ended; cyc++) begin
      if (hs) begin
        cur_r = exp_q[0].r; cur_c = exp_q[0].c;
        void'(exp_q.pop_front());
        ncmd++; hs = 0; stall = 0;
      end
      chk({tag, "/pos_row"}, pos_row, cur_r);
      chk({tag, "/pos_col"}, pos_col, cur_c);
      if (done || error || fail) begin
        chk({tag, "/done"}, done, exp_ok);
        chk({tag, "/error"}, error, !exp_ok);
        chk({tag, "/fail"}, fail, 0);
        chk({tag, "/cmds_left"}, exp_q.size(), 0);
        chk({tag, "/valid_at_end"}, dir_valid, 0);
        ended = 1;
      end else if (dir_valid) begin
        if (exp_q.size() == 0) begin
          chk({tag, "/extra_cmd"}, 1, 0);
          ended = 1;
        end else begin
          if (!seen) begin chk({tag, "/latency"}, cyc, exp_q[0].n); seen = 1; end
          chk({tag, "/dir_data"}, dir_data, exp_q[0].d);
          chk({tag, "/run_len"}, run_len, exp_q[0].n);
          chk({tag, "/busy"}, busy, 1);
          if (ncmd == stall_cmd && stall < 5) begin dir_ready = 1'b0; stall++; end
          else dir_ready = ($urandom_range(0, 99) < rdy_pct);
          hs = dir_ready;
        end
      end else begin
        dir_ready = 1'($urandom_range(0, 1));
      end
      if (!ended) @(negedge clk);
    end
    if (!ended) chk({tag, "/timeout"}, 0, 1);
    dir_ready = 1'b0;
    @(negedge clk);
    chk({tag, "/pulse_clr"}, {29'd0, done, error, fail}, 0);
    chk({tag, "/idle_busy"}, busy, 0);
    chk({tag, "/idle_valid"}, dir_valid, 0);
    chk({tag, "/fin_row"}, pos_row, fin_r);
    chk({tag, "/fin_col"}, pos_col, fin_c);
  endtask

  task automatic fill_junk();
    for (int i = 0; i < 99; i++) path[i] = 4'($urandom_range(0, 15));
  endtask

  // kind 0: monotone goal path; 1: in-grid random walk; 2: unconstrained walk
  task automatic gen_random(output int len);
    int kind, r, c;
    logic [3:0] d;
    kind = $urandom_range(0, 2);
    fill_junk();
    if (kind == 0) begin
      int nn, ee;
      bit pick_n;
      nn = 9; ee = 9; len = 18;
      for (int i = 0; i < 18; i++) begin
        if (nn == 0) pick_n = 0;
        else if (ee == 0) pick_n = 1;
        else if (i > 0 && $urandom_range(0, 9) < 7) pick_n = (path[i-1] == DN);
        else pick_n = 1'($urandom_range(0, 1));
        if (pick_n) begin path[i] = DN; nn--; end
        else begin path[i] = DE; ee--; end
      end
    end else begin
      len = $urandom_range(0, 60);
      r = SR; c = SC; d = DN;
      for (int i = 0; i < len; i++) begin
        int tr, tc;
        if ($urandom_range(0, 9) >= 6) d = 4'(1 << $urandom_range(0, 3));
        if (kind == 1) begin
          for (int t = 0; t < 8; t++) begin
            tr = r; tc = c;
            if (step(int'(d), tr, tc)) break;
            d = 4'(1 << $urandom_range(0, 3));
          end
          tr = r; tc = c;
          if (!step(int'(d), tr, tc)) d = (r > 0) ? DN : DS;
        end else if ($urandom_range(0, 19) == 0) begin
          d = 4'($urandom_range(0, 15));
        end
        path[i] = d;
        void'(step(int'(d), r, c));
      end
    end
  endtask

  initial begin
    int len;
    rst = 1'b1; path_ready = 1'b0; no_path = 1'b0; dir_ready = 1'b0;
    path_length = '0; path = '0;
    #1;
    chk("rst/valid", dir_valid, 0);
    chk("rst/dir_data", dir_data, 0);
    chk("rst/run_len", run_len, 1);
    chk("rst/pos_row", pos_row, SR);
    chk("rst/pos_col", pos_col, SC);
    chk("rst/flags", {28'd0, busy, done, error, fail}, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // nine north then nine east: reaches goal
    fill_junk();
    for (int i = 0; i < 9; i++) path[i] = DN;
    for (int i = 9; i < 18; i++) path[i] = DE;
    run_path("goal18", 18, 100, -1);

    // second command stalled for 5 cycles
    fill_junk();
    path[0] = DN; path[1] = DN; path[2] = DE;
    run_path("stall", 3, 100, 1);

    // illegal code at entry 2
    fill_junk();
    path[0] = DN; path[1] = DN; path[2] = 4'b0011;
    run_path("illegal", 3, 100, -1);

    // first step leaves the grid
    fill_junk();
    path[0] = DS;
    run_path("offgrid", 1, 100, -1);

    // empty path from a non-goal start
    fill_junk();
    run_path("len0", 0, 100, -1);

    // length above 99 is clamped
    for (int i = 0; i < 99; i++) path[i] = (i % 2 == 0) ? DN : DS;
    run_path("clamp", 120, 80, -1);

    // no_path wins over path_ready; rearm needs both low
    no_path = 1'b1; path_ready = 1'b1;
    @(negedge clk);
    chk("nopath/fail1", fail, 1);
    chk("nopath/busy1", busy, 0);
    chk("nopath/de1", {30'd0, done, error}, 0);
    @(negedge clk);
    chk("nopath/fail_held", fail, 0);
    chk("nopath/busy_held", busy, 0);
    no_path = 1'b0; path_ready = 1'b0;
    @(negedge clk);
    chk("nopath/fail_low", fail, 0);
    no_path = 1'b1;
    @(negedge clk);
    chk("nopath/fail2", fail, 1);
    no_path = 1'b0;
    @(negedge clk);
    chk("nopath/fail2_clr", fail, 0);

    // reset during STREAM after one accepted command
    fill_junk();
    path[0] = DN; path[1] = DS; path[2] = DN; path[3] = DS; path[4] = DN;
    path_length = 7'd5; path_ready = 1'b1;
    @(negedge clk);
    path_ready = 1'b0; dir_ready = 1'b0;
    for (int k = 0; k < 20 && !dir_valid; k++) @(negedge clk);
    chk("rstmid/valid1", dir_valid, 1);
    dir_ready = 1'b1;
    @(negedge clk);
    dir_ready = 1'b0;
    for (int k = 0; k < 20 && !dir_valid; k++) @(negedge clk);
    chk("rstmid/valid2", dir_valid, 1);
    chk("rstmid/row_before", pos_row, SR - 1);
    rst = 1'b1;
    #1;
    chk("rstmid/valid", dir_valid, 0);
    chk("rstmid/dir_data", dir_data, 0);
    chk("rstmid/run_len", run_len, 1);
    chk("rstmid/pos_row", pos_row, SR);
    chk("rstmid/pos_col", pos_col, SC);
    chk("rstmid/flags", {28'd0, busy, done, error, fail}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid/after", {27'd0, dir_valid, busy, done, error, fail}, 0);
    for (int i = 0; i < 9; i++) path[i] = DN;
    for (int i = 9; i < 18; i++) path[i] = DE;
    run_path("after_rst", 18, 70, -1);

    // randomized paths
    for (int t = 0; t < 40; t++) begin
      gen_random(len);
      run_path($sformatf("rand%0d", t), len, $urandom_range(30, 100), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
